// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the two-port memory arbiter.
// Port numbering: CPU is port 0, loader/debug DMA is port 1.
package mem_arb_pkg;
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } arb_state_t;

   localparam int PORT_CPU     = 0;
   localparam int PORT_DMA     = 1;
   localparam int ADDR_W_DEF   = 8;
   localparam int DATA_W_DEF   = 16;
   localparam int LOCK_MAX_DEF = 4;

   function automatic arb_state_t own_state(input logic port);
      return port ? OWN1 : OWN0;
   endfunction
endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin picker; zero latency.
// On a tie the port that did not win last time is granted.
module rr_pick2
   import mem_arb_pkg::*;
(
   input  logic       i_last,
   input  logic [1:0] i_req,
   output logic [1:0] o_gnt
);
   always_comb begin
      o_gnt = i_req;
      if (i_req == 2'b11) begin
         o_gnt = 2'b00;
         o_gnt[i_last ? PORT_CPU : PORT_DMA] = 1'b1;
      end
   end
endmodule

// File: rtl/mem_port_arbiter.sv
// Two-port arbiter for a single-ported word RAM: combinational grant, reads return 1 cycle later.
// Ungranted ports simply hold req; a lock keeps ownership until the starvation counter breaks it.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int DATA_W   = DATA_W_DEF,
   parameter int LOCK_MAX = LOCK_MAX_DEF
)(
   input  logic              clk,
   input  logic              rst,
   input  logic [1:0]        req_i,
   input  logic [1:0]        lock_i,
   input  logic [1:0]        we_i,
   input  logic [ADDR_W-1:0] addr0_i,
   input  logic [ADDR_W-1:0] addr1_i,
   input  logic [DATA_W-1:0] wdata0_i,
   input  logic [DATA_W-1:0] wdata1_i,
   output logic [1:0]        gnt_o,
   output logic [1:0]        rvalid_o,
   output logic [DATA_W-1:0] rdata_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic              mem_we_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   input  logic [DATA_W-1:0] mem_rdata_i
);
   localparam int CNT_W = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;
   localparam logic [CNT_W-1:0] CNT_BREAK = CNT_W'(LOCK_MAX - 1);
   localparam logic [CNT_W-1:0] CNT_SAT   = {CNT_W{1'b1}};

   arb_state_t       r_state;
   logic             r_last;
   logic [CNT_W-1:0] r_cnt;
   logic [1:0]       r_rvalid;

   arb_state_t       w_state_nxt;
   logic             w_last_nxt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic [CNT_W-1:0] w_cnt_inc;
   logic             w_owned;
   logic             w_own_port;
   logic             w_other;
   logic             w_hold;
   logic             w_rr_last;
   logic [1:0]       w_rr_gnt;
   logic [1:0]       w_gnt;

   assign w_owned    = (r_state != IDLE);
   assign w_own_port = (r_state == OWN1);
   assign w_other    = ~w_own_port;
   assign w_hold     = w_owned && req_i[w_own_port] && lock_i[w_own_port];
   assign w_rr_last  = w_owned ? w_own_port : r_last;
   assign w_cnt_inc  = (r_cnt == CNT_SAT) ? r_cnt : r_cnt + 1'b1;

   rr_pick2 u_pick (
      .i_last (w_rr_last),
      .i_req  (req_i),
      .o_gnt  (w_rr_gnt)
   );

   always_comb begin
      w_gnt = 2'b00;
      if (!rst) begin
         if (w_hold) begin
            w_gnt[w_own_port] = 1'b1;
         end else begin
            w_gnt = w_rr_gnt;
         end
      end
   end

   always_comb begin
      mem_addr_o  = '0;
      mem_we_o    = 1'b0;
      mem_wdata_o = '0;
      if (w_gnt[PORT_CPU]) begin
         mem_addr_o  = addr0_i;
         mem_we_o    = we_i[PORT_CPU];
         mem_wdata_o = wdata0_i;
      end else if (w_gnt[PORT_DMA]) begin
         mem_addr_o  = addr1_i;
         mem_we_o    = we_i[PORT_DMA];
         mem_wdata_o = wdata1_i;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_last_nxt  = r_last;
      w_cnt_nxt   = r_cnt;
      if (w_hold) begin
         // Count only cycles where the other port is actually waiting.
         if (req_i[w_other]) begin
            w_cnt_nxt = w_cnt_inc;
            if (w_cnt_inc >= CNT_BREAK) begin
               w_state_nxt = IDLE;
               w_last_nxt  = w_own_port;
            end
         end
      end else if (|w_gnt) begin
         w_last_nxt = w_gnt[PORT_DMA];
         if (lock_i[w_gnt[PORT_DMA]]) begin
            w_state_nxt = own_state(w_gnt[PORT_DMA]);
            w_cnt_nxt   = '0;
         end else begin
            w_state_nxt = IDLE;
         end
      end else begin
         w_state_nxt = IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= IDLE;
         r_last   <= 1'b1;
         r_cnt    <= '0;
         r_rvalid <= 2'b00;
      end else begin
         r_state  <= w_state_nxt;
         r_last   <= w_last_nxt;
         r_cnt    <= w_cnt_nxt;
         r_rvalid <= w_gnt & ~we_i;
      end
   end

   assign gnt_o    = w_gnt;
   assign rvalid_o = r_rvalid & {2{~rst}};
   assign rdata_o  = mem_rdata_i;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios then randomized traffic against a transaction-level model.
module tb_mem_port_arbiter;
   localparam int LOCK_MAX = 4;

   logic        clk;
   logic        rst;
   logic [1:0]  req_i, lock_i, we_i;
   logic [7:0]  addr0_i, addr1_i;
   logic [15:0] wdata0_i, wdata1_i;
   logic [1:0]  gnt_o, rvalid_o;
   logic [15:0] rdata_o;
   logic [7:0]  mem_addr_o;
   logic        mem_we_o;
   logic [15:0] mem_wdata_o;
   logic [15:0] mem_rdata_i;

   mem_port_arbiter #(.ADDR_W(8), .DATA_W(16), .LOCK_MAX(LOCK_MAX)) dut (
      .clk         (clk),
      .rst         (rst),
      .req_i       (req_i),
      .lock_i      (lock_i),
      .we_i        (we_i),
      .addr0_i     (addr0_i),
      .addr1_i     (addr1_i),
      .wdata0_i    (wdata0_i),
      .wdata1_i    (wdata1_i),
      .gnt_o       (gnt_o),
      .rvalid_o    (rvalid_o),
      .rdata_o     (rdata_o),
      .mem_addr_o  (mem_addr_o),
      .mem_we_o    (mem_we_o),
      .mem_wdata_o (mem_wdata_o),
      .mem_rdata_i (mem_rdata_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [15:0] pat(input int i);
      return (i == 8) ? 16'hBEEF : 16'((i * 16'h0101) ^ 16'h5A5A);
   endfunction

   // Write-first synchronous RAM the arbiter drives.
   logic        ram_init;
   logic [15:0] ram [0:127];
   always @(posedge clk) begin
      if (ram_init) begin
         for (int i = 0; i < 128; i++) ram[i] <= pat(i);
         mem_rdata_i <= 16'h0000;
      end else begin
         if (mem_we_o) ram[mem_addr_o[7:1]] <= mem_wdata_o;
         mem_rdata_i <= mem_we_o ? mem_wdata_o : ram[mem_addr_o[7:1]];
      end
   end

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: who owns the bus, who won last, how long the other port has waited.
   int          m_owner;
   int          m_last;
   int          m_waits;
   logic [1:0]  m_pend;
   logic [15:0] m_pend_dat;
   logic [15:0] ref_mem [0:127];
   logic [1:0]  obs_gnt, obs_rvalid;
   logic [15:0] obs_rdata;

   task automatic cyc(input logic r, input logic [1:0] rq, input logic [1:0] lk, input logic [1:0] w,
                      input logic [7:0] a0, input logic [7:0] a1, input logic [15:0] d0, input logic [15:0] d1);
      int          g;
      logic        held;
      logic [1:0]  eg;
      logic        ewe;
      logic [7:0]  ea;
      logic [15:0] ed;
      @(negedge clk);
      rst = r; req_i = rq; lock_i = lk; we_i = w;
      addr0_i = a0; addr1_i = a1; wdata0_i = d0; wdata1_i = d1;
      #1;
      held = (m_owner >= 0) && rq[m_owner] && lk[m_owner];
      if (r)                 g = -1;
      else if (held)         g = m_owner;
      else if (rq == 2'b11)  g = 1 - m_last;
      else if (rq[0])        g = 0;
      else if (rq[1])        g = 1;
      else                   g = -1;
      eg = 2'b00; ewe = 1'b0; ea = 8'h00; ed = 16'h0000;
      if (g >= 0) begin
         eg[g] = 1'b1;
         ewe   = w[g];
         ea    = (g == 0) ? a0 : a1;
         ed    = (g == 0) ? d0 : d1;
      end
      chk("gnt", 32'(gnt_o), 32'(eg));
      chk("mem_we", 32'(mem_we_o), 32'(ewe));
      chk("mem_addr", 32'(mem_addr_o), 32'(ea));
      chk("mem_wdata", 32'(mem_wdata_o), 32'(ed));
      chk("rvalid", 32'(rvalid_o), r ? 32'd0 : 32'(m_pend));
      if (!r && m_pend != 2'b00) chk("rdata", 32'(rdata_o), 32'(m_pend_dat));
      obs_gnt = gnt_o; obs_rvalid = rvalid_o; obs_rdata = rdata_o;

      if (r) begin
         m_owner = -1; m_last = 1; m_waits = 0; m_pend = 2'b00;
      end else begin
         m_pend = 2'b00;
         if (g >= 0) begin
            if (w[g]) ref_mem[ea[7:1]] = ed;
            else begin
               m_pend[g]  = 1'b1;
               m_pend_dat = ref_mem[ea[7:1]];
            end
         end
         if (held) begin
            if (rq[1 - m_owner]) begin
               m_waits++;
               if (m_waits >= LOCK_MAX - 1) m_owner = -1;
            end
         end else if (g >= 0) begin
            m_last  = g;
            m_owner = lk[g] ? g : -1;
            m_waits = 0;
         end else begin
            m_owner = -1;
         end
      end
   endtask

   logic [1:0]  p_act, p_we, p_lk;
   logic [7:0]  p_addr [2];
   logic [15:0] p_dat  [2];
   logic [1:0]  exp_seq [4];

   initial begin
      rst = 1'b1; ram_init = 1'b1;
      req_i = 2'b00; lock_i = 2'b00; we_i = 2'b00;
      addr0_i = 8'h00; addr1_i = 8'h00; wdata0_i = 16'h0; wdata1_i = 16'h0;
      for (int i = 0; i < 128; i++) ref_mem[i] = pat(i);
      m_owner = -1; m_last = 1; m_waits = 0; m_pend = 2'b00; m_pend_dat = 16'h0;
      @(posedge clk);
      #1 ram_init = 1'b0;

      // Reset held with both ports requesting writes.
      for (int i = 0; i < 2; i++) begin
         cyc(1'b1, 2'b11, 2'b00, 2'b11, 8'h10, 8'h20, 16'hAAAA, 16'h5555);
         chk("rst_gnt", 32'(obs_gnt), 32'd0);
         chk("rst_rvalid", 32'(obs_rvalid), 32'd0);
      end

      // Contention straight out of reset.
      exp_seq[0] = 2'b01; exp_seq[1] = 2'b10; exp_seq[2] = 2'b01; exp_seq[3] = 2'b10;
      for (int i = 0; i < 4; i++) begin
         cyc(1'b0, 2'b11, 2'b00, 2'b00, 8'h10, 8'h20, 16'h0, 16'h0);
         chk("rr_seq", 32'(obs_gnt), 32'(exp_seq[i]));
      end
      cyc(1'b0, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 16'h0, 16'h0);

      // Single read of word 8.
      cyc(1'b0, 2'b01, 2'b00, 2'b00, 8'h10, 8'h00, 16'h0, 16'h0);
      chk("rd_gnt", 32'(obs_gnt), 32'h1);
      cyc(1'b0, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 16'h0, 16'h0);
      chk("rd_rvalid", 32'(obs_rvalid), 32'h1);
      chk("rd_data", 32'(obs_rdata), 32'hBEEF);

      // DMA write then CPU read-back of the same word.
      cyc(1'b0, 2'b10, 2'b00, 2'b10, 8'h00, 8'h20, 16'h0, 16'h1234);
      chk("wr_gnt", 32'(obs_gnt), 32'h2);
      cyc(1'b0, 2'b01, 2'b00, 2'b00, 8'h20, 8'h00, 16'h0, 16'h0);
      chk("wr_rd_gnt", 32'(obs_gnt), 32'h1);
      cyc(1'b0, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 16'h0, 16'h0);
      chk("wr_rd_data", 32'(obs_rdata), 32'h1234);

      // DMA read so the CPU wins the next tie, then CPU locks while DMA waits.
      cyc(1'b0, 2'b10, 2'b00, 2'b00, 8'h00, 8'h30, 16'h0, 16'h0);
      cyc(1'b0, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 16'h0, 16'h0);
      for (int i = 0; i < LOCK_MAX; i++) begin
         cyc(1'b0, 2'b11, 2'b01, 2'b00, 8'h12, 8'h34, 16'h0, 16'h0);
         chk("lock_own", 32'(obs_gnt), 32'h1);
      end
      cyc(1'b0, 2'b11, 2'b01, 2'b00, 8'h12, 8'h34, 16'h0, 16'h0);
      chk("lock_break", 32'(obs_gnt), 32'h2);
      cyc(1'b0, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 16'h0, 16'h0);

      // DMA takes ownership, reset lands while its read is in flight.
      cyc(1'b0, 2'b10, 2'b10, 2'b00, 8'h00, 8'h40, 16'h0, 16'h0);
      chk("own1_gnt", 32'(obs_gnt), 32'h2);
      cyc(1'b0, 2'b10, 2'b10, 2'b00, 8'h00, 8'h42, 16'h0, 16'h0);
      chk("own1_hold", 32'(obs_gnt), 32'h2);
      cyc(1'b1, 2'b10, 2'b10, 2'b00, 8'h00, 8'h44, 16'h0, 16'h0);
      chk("midrst_rvalid", 32'(obs_rvalid), 32'd0);
      chk("midrst_gnt", 32'(obs_gnt), 32'd0);
      cyc(1'b0, 2'b11, 2'b00, 2'b00, 8'h02, 8'h04, 16'h0, 16'h0);
      chk("postrst_gnt", 32'(obs_gnt), 32'h1);
      chk("postrst_rvalid", 32'(obs_rvalid), 32'd0);
      cyc(1'b0, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 16'h0, 16'h0);

      // Randomized traffic: requests held until granted, slowly toggling locks.
      p_act = 2'b00; p_we = 2'b00; p_lk = 2'b00;
      for (int p = 0; p < 2; p++) begin p_addr[p] = 8'h00; p_dat[p] = 16'h0; end
      for (int n = 0; n < 3000; n++) begin
         for (int p = 0; p < 2; p++) begin
            if ($urandom_range(0, 7) == 0) p_lk[p] = ~p_lk[p];
            if (!p_act[p] && $urandom_range(0, 99) < 65) begin
               p_act[p]  = 1'b1;
               p_we[p]   = ($urandom_range(0, 2) == 0);
               p_addr[p] = 8'($urandom_range(0, 31));
               p_dat[p]  = 16'($urandom);
            end
         end
         cyc(($urandom_range(0, 249) == 0), p_act, p_lk, p_we, p_addr[0], p_addr[1], p_dat[0], p_dat[1]);
         p_act = p_act & ~obs_gnt;
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
